// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexes NUM_DIGITS 4-bit codes onto one shared segment decoder.
// Each digit owns a PRESCALE-cycle slot whose first BLANK_CYCLES cycles keep
// every digit dark to avoid ghosting. New codes arrive through a load/ack
// handshake into a shadow register and are committed to the active register
// only on the last cycle of the final digit's slot, so a frame never mixes
// old and new data. All outputs are registered.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic                      load_ack,
  output logic [3:0]                dec_code,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_start
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phaseType;

  phaseType                  phase, phaseNext;
  logic [CNT_W-1:0]          slotCnt, slotCntNext;
  logic [IDX_W-1:0]          digitIdx, digitIdxNext;
  logic [4*NUM_DIGITS-1:0]   shadowReg, shadowNext;
  logic [4*NUM_DIGITS-1:0]   activeReg, activeNext;
  logic                      pending, pendingNext;
  logic                      loadAckReg, loadAckNext;
  logic [3:0]                decCodeReg, decCodeNext;
  logic [NUM_DIGITS-1:0]     digitEnReg, digitEnNext;
  logic                      frameStartReg, frameStartNext;
  logic                      slotEnd;

  assign slotEnd = (slotCnt == LAST_SLOT);

  // Next-state logic: counters, blank/show phase, handshake and frame commit
  always_comb begin
    phaseNext      = phase;
    slotCntNext    = slotCnt;
    digitIdxNext   = digitIdx;
    shadowNext     = shadowReg;
    activeNext     = activeReg;
    pendingNext    = pending;
    loadAckNext    = 1'b0;
    decCodeNext    = decCodeReg;
    digitEnNext    = '0;
    frameStartNext = 1'b0;

    // Capture is independent of enable; a full shadow back-pressures load
    if (load && !pending) begin
      shadowNext  = load_data;
      pendingNext = 1'b1;
      loadAckNext = 1'b1;
    end

    if (enable) begin
      frameStartNext = (slotCnt == '0) && (digitIdx == '0);

      if (slotCnt == '0) begin
        decCodeNext = activeReg[{digitIdx, 2'b00} +: 4];
      end

      unique case (phase)
        BLANK: begin
          if (slotCnt == BLANK_LAST) begin
            phaseNext = SHOW;
          end
        end
        SHOW: begin
          digitEnNext = NUM_DIGITS'(1) << digitIdx;
          if (slotEnd) begin
            phaseNext = BLANK;
          end
        end
        default: phaseNext = BLANK;
      endcase

      if (slotEnd) begin
        slotCntNext = '0;
        if (digitIdx == LAST_DIGIT) begin
          digitIdxNext = '0;
          // Commit and capture are exclusive: commit needs pending, capture needs it clear
          if (pending) begin
            activeNext  = shadowReg;
            pendingNext = 1'b0;
          end
        end else begin
          digitIdxNext = digitIdx + IDX_W'(1);
        end
      end else begin
        slotCntNext = slotCnt + CNT_W'(1);
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase         <= BLANK;
      slotCnt       <= '0;
      digitIdx      <= '0;
      shadowReg     <= '0;
      activeReg     <= '0;
      pending       <= 1'b0;
      loadAckReg    <= 1'b0;
      decCodeReg    <= '0;
      digitEnReg    <= '0;
      frameStartReg <= 1'b0;
    end else begin
      phase         <= phaseNext;
      slotCnt       <= slotCntNext;
      digitIdx      <= digitIdxNext;
      shadowReg     <= shadowNext;
      activeReg     <= activeNext;
      pending       <= pendingNext;
      loadAckReg    <= loadAckNext;
      decCodeReg    <= decCodeNext;
      digitEnReg    <= digitEnNext;
      frameStartReg <= frameStartNext;
    end
  end

  assign load_ack    = loadAckReg;
  assign dec_code    = decCodeReg;
  assign digit_en    = digitEnReg;
  assign frame_start = frameStartReg;

endmodule
